// File: rtl/movement_scheduler.sv
// -----------------------------------------------------------------------------
// movement_scheduler
//   Arbitrates between a manual (A, high-priority) and an autonomous (B,
//   low-priority) movement request stream and drives a single registered
//   movement code to the motor controller. Each movement runs for a number of
//   duration ticks, followed by a motor dead-time with the stop code applied.
//   A manual request may preempt a running autonomous movement; an emergency
//   stop forces the stop code and discards any pending work.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   estop          synchronous emergency stop, highest priority
//   a_valid/a_ready, a_move[3:0], a_dur[7:0]   manual request handshake
//   b_valid/b_ready, b_move[3:0], b_dur[7:0]   autonomous request handshake
//   movement_sel[3:0]  registered movement code to the motor controller
//   busy               high in every state except IDLE
//   active_src         source of current/last movement (0 = A, 1 = B)
//   done               one-cycle pulse on natural completion of a movement
// -----------------------------------------------------------------------------
module movement_scheduler #(
    parameter int         TICK_DIV   = 1000,
    parameter int         DEAD_TICKS = 2,
    parameter logic [3:0] STOP_CODE  = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       estop,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [3:0] a_move,
    input  logic [7:0] a_dur,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [3:0] b_move,
    input  logic [7:0] b_dur,
    output logic [3:0] movement_sel,
    output logic       busy,
    output logic       active_src,
    output logic       done
);

    localparam int               CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]       DEAD_LEFT = 8'(DEAD_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DEAD  = 2'd2,
        S_ESTOP = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [7:0]       r_left;        // ticks remaining in the current RUN/DEAD phase
    logic [3:0]       r_movement_sel;
    logic             r_done;
    logic             r_active_src;
    logic             r_pend_vld;
    logic [3:0]       r_pend_move;
    logic [7:0]       r_pend_dur;

    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_a_fire;
    logic             w_b_fire;
    logic             w_tick;
    logic             w_last;
    logic [3:0]       w_load_move;
    logic [7:0]       w_load_dur;
    logic [7:0]       w_load_left;

    assign w_tick = (r_tick_cnt == CNT_MAX);
    // Idle/ESTOP keep r_left at 0, so this only fires at the end of RUN/DEAD.
    assign w_last = w_tick && (r_left == 8'd1);

    // A movement entering RUN from DEAD is always the held preemptor.
    assign w_load_move = (r_state == S_DEAD) ? r_pend_move :
                         (w_a_fire ? a_move : b_move);
    assign w_load_dur  = (r_state == S_DEAD) ? r_pend_dur :
                         (w_a_fire ? a_dur : b_dur);
    assign w_load_left = (w_load_dur == 8'd0) ? 8'd1 : w_load_dur;

    always_comb begin
        w_state_nxt = r_state;
        w_a_ready   = 1'b0;
        w_b_ready   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_a_ready = !estop;
                w_b_ready = !estop && !a_valid;
            end
            S_RUN:   w_a_ready = !estop && r_active_src && !r_pend_vld;
            default: ;
        endcase

        if (!rst) begin
            w_a_ready = 1'b0;
            w_b_ready = 1'b0;
        end

        w_a_fire = a_valid && w_a_ready;
        w_b_fire = b_valid && w_b_ready;

        case (r_state)
            S_IDLE:  if (w_a_fire || w_b_fire) w_state_nxt = S_RUN;
            S_RUN:   if (w_a_fire || w_last)   w_state_nxt = S_DEAD;
            S_DEAD:  if (w_last) w_state_nxt = r_pend_vld ? S_RUN : S_IDLE;
            S_ESTOP: if (!estop)  w_state_nxt = S_DEAD;
            default: w_state_nxt = S_IDLE;
        endcase

        if (estop) w_state_nxt = S_ESTOP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_tick_cnt     <= '0;
            r_left         <= 8'd0;
            r_movement_sel <= STOP_CODE;
            r_done         <= 1'b0;
            r_active_src   <= 1'b0;
            r_pend_vld     <= 1'b0;
            r_pend_move    <= 4'd0;
            r_pend_dur     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            // Every phase change restarts the tick divider from zero.
            if ((w_state_nxt != r_state) || ((r_state != S_RUN) && (r_state != S_DEAD)))
                r_tick_cnt <= '0;
            else if (w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;

            if ((w_state_nxt == S_RUN) && (r_state != S_RUN))
                r_left <= w_load_left;
            else if ((w_state_nxt == S_DEAD) && (r_state != S_DEAD))
                r_left <= DEAD_LEFT;
            else if (w_state_nxt != r_state)
                r_left <= 8'd0;
            else if (w_tick && ((r_state == S_RUN) || (r_state == S_DEAD)))
                r_left <= r_left - 8'd1;

            if ((w_state_nxt == S_RUN) && (r_state != S_RUN))
                r_movement_sel <= w_load_move;
            else if (w_state_nxt != S_RUN)
                r_movement_sel <= STOP_CODE;

            // Preemption also leaves RUN for DEAD but is not a natural end.
            r_done <= (r_state == S_RUN) && (w_state_nxt == S_DEAD) && !w_a_fire;

            if (w_state_nxt == S_ESTOP) begin
                r_pend_vld <= 1'b0;
            end else if ((r_state == S_RUN) && w_a_fire) begin
                r_pend_vld  <= 1'b1;
                r_pend_move <= a_move;
                r_pend_dur  <= a_dur;
            end else if ((r_state == S_DEAD) && (w_state_nxt == S_RUN)) begin
                r_pend_vld <= 1'b0;
            end

            if ((r_state == S_IDLE) && (w_state_nxt == S_RUN))
                r_active_src <= !w_a_fire;
            else if ((r_state == S_DEAD) && (w_state_nxt == S_RUN))
                r_active_src <= 1'b0;
        end
    end

    assign a_ready      = w_a_ready;
    assign b_ready      = w_b_ready;
    assign movement_sel = r_movement_sel;
    assign busy         = (r_state != S_IDLE);
    assign active_src   = r_active_src;
    assign done         = r_done;

endmodule

// File: doc/movement_scheduler.md
MOVEMENT_SCHEDULER -- requirements
Module: movement_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, clock cycles per duration tick (>=2).
REQ-002 SHALL have parameter DEAD_TICKS, default 2, motor dead-time in ticks between movements (>=1).
REQ-003 SHALL have parameter STOP_CODE, default 4'h0, movement code meaning all motors stopped.
REQ-004 Ports: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 estop  input  1  synchronous emergency stop, highest priority.
REQ-008 a_valid / a_ready  input / output  1 / 1  manual (high-priority) request handshake.
REQ-009 a_move / a_dur  input  4 / 8  manual movement code / duration in ticks.
REQ-010 b_valid / b_ready  input / output  1 / 1  autonomous (low-priority) request handshake.
REQ-011 b_move / b_dur  input  4 / 8  autonomous movement code / duration in ticks.
REQ-012 movement_sel  output  4  registered movement code driving the motor controller.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 active_src  output  1  source of current/last movement: 0 = A, 1 = B.
REQ-015 done  output  1  one-cycle pulse on natural completion of a movement.

Function
REQ-016 States SHALL be IDLE, RUN, DEAD, ESTOP.
REQ-017 Transfer SHALL occur on a rising edge with valid && ready; move/dur SHALL be sampled at that edge.
REQ-018 a_ready SHALL be high in IDLE, and in RUN with active_src=1 and no pending request, both only while estop=0; otherwise low.
REQ-019 b_ready SHALL be high only in IDLE with estop=0 and a_valid=0. A always wins a simultaneous request.
REQ-020 Accept in IDLE -> RUN: movement_sel = move from the next cycle; tick counter cleared to 0.
REQ-021 Tick counter SHALL count 0..TICK_DIV-1 and wrap. A tick occurs when count = TICK_DIV-1.
REQ-022 RUN SHALL last exactly max(dur,1) x TICK_DIV cycles. dur=0 is treated as 1.
REQ-023 Natural RUN end -> DEAD: done pulses for 1 cycle; movement_sel = STOP_CODE.
REQ-024 DEAD SHALL last exactly DEAD_TICKS x TICK_DIV cycles with movement_sel = STOP_CODE.
REQ-025 Preemption: an A transfer during a B RUN SHALL:
  - store A in a one-entry pending register;
  - enter DEAD next cycle with the counters cleared;
  - leave done unpulsed.
REQ-026 DEAD end SHALL go to RUN with the pending request if one is held (active_src=0, pending cleared); otherwise to IDLE.
REQ-027 No acceptance SHALL occur on the DEAD->IDLE edge; the earliest acceptance is the following edge.
REQ-028 estop=1 in any state SHALL on the next edge:
  - enter ESTOP;
  - set movement_sel = STOP_CODE;
  - clear the pending register and counters;
  - keep done at 0.
REQ-029 estop falling while in ESTOP SHALL enter DEAD (full dead-time), then IDLE.
REQ-030 estop SHALL override a same-cycle handshake: ready=0, so no transfer.
REQ-031 Movement codes SHALL pass through unmodified. Only STOP_CODE is inserted by this block.

Reset
REQ-032 rst=0 SHALL immediately force:
  - state=IDLE;
  - movement_sel=STOP_CODE;
  - busy=0, done=0, active_src=0;
  - pending empty;
  - counters 0.
REQ-033 With rst=0, a_ready and b_ready SHALL be 0.
REQ-034 Reset asserted mid-RUN or mid-DEAD SHALL abort the movement with no done pulse.

Verification (TICK_DIV=4, DEAD_TICKS=2, STOP_CODE=0)
REQ-035 Reset: rst=0 during RUN with move 3 -> movement_sel=0, busy=0 asynchronously; after release, IDLE with a_ready=1.
REQ-036 Single B request (move 3, dur 2) -> movement_sel=3 for 8 cycles, done pulse, 0 for 8 cycles, then IDLE.
REQ-037 Simultaneous A (5, dur 1) and B (3, dur 1) in IDLE -> A accepted, b_ready=0, movement_sel=5 for 4 cycles.
REQ-038 Preemption: A (6, dur 1) arrives 5 cycles into B (3, dur 10) -> 0 for 8 cycles, 6 for 4 cycles, one done pulse (for A only).
REQ-039 estop pulse mid-RUN with a pending request -> 0 next cycle, pending dropped, 8 cycles of 0 after release, then IDLE.
REQ-040 dur=0 request (move 9) -> movement_sel=9 for exactly 4 cycles.
